// File: rtl/lcd_spi_feeder_if.sv
// Bundle between the pixel/command generator, the LCD feeder and the byte-level SPI master.
// The feeder uses the slave view; the generator/SPI side uses the master view.
interface lcd_spi_feeder_if #(
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_dc;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              spi_start;
    logic [7:0]        spi_data;
    logic              spi_busy;
    logic              spi_new_data;
    logic              lcd_dc;
    logic [ADDR_W:0]   fifo_count;
    logic              idle;

    modport slave (
        input  in_valid, in_dc, in_data, spi_busy, spi_new_data,
        output in_ready, spi_start, spi_data, lcd_dc, fifo_count, idle
    );

    modport master (
        output in_valid, in_dc, in_data, spi_busy, spi_new_data,
        input  in_ready, spi_start, spi_data, lcd_dc, fifo_count, idle
    );
endinterface

// File: rtl/lcd_spi_feeder.sv
// Buffers {dc, byte} words in a small FIFO and hands them one at a time to the SPI master,
// holding the LCD D/C line for the whole byte and leaving an idle gap between bytes.
module lcd_spi_feeder #(
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 2,
    parameter int GAP_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    lcd_spi_feeder_if.slave    bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_GAP       = 2'd2
    } state_t;

    state_t              r_state;
    logic [8:0]          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_spi_start;
    logic [7:0]          r_spi_data;
    logic                r_lcd_dc;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [8:0]          w_head;

    // in_ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign w_full = (r_count == FULL_CNT);
    assign w_push = bus.in_valid & ~w_full;
    assign w_pop  = (r_state == S_IDLE) & (r_count != '0) & ~bus.spi_busy;
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_dc, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // spi_data and lcd_dc only change on the edge that raises spi_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_spi_start <= 1'b0;
            r_spi_data  <= '0;
            r_lcd_dc    <= 1'b0;
            r_gap_cnt   <= '0;
        end else begin
            r_spi_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_spi_data  <= w_head[7:0];
                        r_lcd_dc    <= w_head[8];
                        r_spi_start <= 1'b1;
                        r_state     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.spi_new_data) begin
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap_cnt <= GAP_LOAD;
                            r_state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = ~w_full;
    assign bus.spi_start  = r_spi_start;
    assign bus.spi_data   = r_spi_data;
    assign bus.lcd_dc     = r_lcd_dc;
    assign bus.fifo_count = r_count;
    assign bus.idle       = (r_count == '0) & (r_state == S_IDLE);
endmodule

// File: doc/lcd_spi_feeder.md
Name: lcd_spi_feeder

Overview:
Upstream stage of the LCD byte-level SPI master. Accepts {dc, byte} words from the pixel/command generator over valid/ready, buffers them in a small FIFO, and issues them one at a time to the SPI master via its start/data_in/busy/new_data handshake. Drives the LCD D/C line, held stable for each byte's whole transfer, and inserts a programmable idle gap between bytes.

Parameters:
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries of 9 bits {dc, data}
GAP_CYCLES, 2, idle clocks after each byte's new_data before the next start; 0 = back-to-back
GAP_W, 4, width of gap counter; GAP_CYCLES must be < 2**GAP_W

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  upstream word valid
in_dc  in  1  0 = command byte, 1 = data byte
in_data  in  8  byte to send
in_ready  out  1  FIFO can accept; push = in_valid & in_ready
spi_start  out  1  one-cycle start pulse to SPI master
spi_data  out  8  byte to SPI master data_in; registered
spi_busy  in  1  SPI master busy
spi_new_data  in  1  SPI master byte-complete pulse
lcd_dc  out  1  LCD data/command select; registered
fifo_count  out  ADDR_W+1  current FIFO occupancy, 0..2**ADDR_W
idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (rst low, async): FIFO pointers/count = 0, state = IDLE, spi_start = 0, spi_data = 0, lcd_dc = 0, gap counter = 0. Outputs: in_ready = 1, fifo_count = 0, idle = 1. FIFO contents discarded; any in-flight byte is abandoned (the SPI master has its own reset).
- FIFO: circular, wr/rd pointers wrap modulo 2**ADDR_W; count is ADDR_W+1 bits, so full = count == 2**ADDR_W. in_ready = !full, from registered count only (no combinational path from pop).
- Push when full is impossible (in_ready = 0); in_valid with in_ready = 0 is ignored, no data lost from FIFO.
- Simultaneous push and pop: count unchanged, both pointers advance. Pop when full + push attempt: push refused that cycle (in_ready was 0).
- FSM states: IDLE, WAIT_DONE, GAP.
- IDLE: if count != 0 and spi_busy == 0 -> pop head; at the same edge register spi_data = head.data, lcd_dc = head.dc, spi_start = 1; go WAIT_DONE. Otherwise stay; spi_start = 0.
- WAIT_DONE: spi_start = 0 (high exactly one cycle). spi_data and lcd_dc held. On spi_new_data = 1 -> if GAP_CYCLES == 0 go IDLE, else load gap counter = GAP_CYCLES - 1, go GAP. spi_busy ignored in this state.
- GAP: counter decrements each clock; at 0 go IDLE. lcd_dc, spi_data held.
- spi_new_data outside WAIT_DONE: ignored.
- Latency: push accepted at edge k into empty FIFO with FSM IDLE and spi_busy = 0 -> spi_start high in the cycle after edge k+1.
- Back-to-back throughput: new_data at edge n -> next spi_start edge n+GAP_CYCLES+1 (if FIFO non-empty).
- lcd_dc changes only at a start edge, never mid-byte.
- idle = (count == 0) & (state == IDLE), combinational from registers.

Test Plan:
- Reset: hold rst = 0 mid-transfer with 5 words queued -> in_ready = 1, fifo_count = 0, spi_start = 0, lcd_dc = 0, idle = 1 immediately (async).
- Single byte: push {dc=0, 0x2A} into empty FIFO, SPI model idle -> spi_start one cycle, spi_data = 0x2A, lcd_dc = 0 two edges after push; idle = 1 after new_data + GAP_CYCLES clocks.
- Stream: push 0x2C(cmd), 0x11, 0x22, 0x33(data) with behavioural SPI master (busy 1 cycle after start, new_data after 8 bit-times) -> bytes emitted in order, lcd_dc 0,1,1,1, exactly GAP_CYCLES = 2 idle clocks between new_data and next start.
- Full: push 16 words with SPI model stalled (busy = 1) -> fifo_count = 16, in_ready = 0; 17th word held with in_valid = 1 is accepted only after first pop; no loss or duplication across pointer wrap (push 40 words total, check order).
- Simultaneous push/pop at count = 1 -> fifo_count stays 1; GAP_CYCLES = 0 build -> next start one edge after new_data.
- Busy gating: spi_busy = 1 with FIFO non-empty in IDLE -> no spi_start until spi_busy falls; spurious spi_new_data in IDLE -> no state change.
